// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch hazard stall sequencer and one-cycle resolve pulse.
// Optional feature: define MIPS_DELAY_SLOT_EN to keep the delay-slot instruction (flush_if tied low).

`ifndef OP_BEQ
`define OP_BEQ  6'h04
`endif
`ifndef OP_BNE
`define OP_BNE  6'h05
`endif
`ifndef OP_BLEZ
`define OP_BLEZ 6'h06
`endif
`ifndef OP_BGTZ
`define OP_BGTZ 6'h07
`endif
`ifndef OP_BGEZ
`define OP_BGEZ 6'h01
`endif

module branch_resolve_ctrl #(
    parameter int ALU_STALLS  = 1,
    parameter int LOAD_STALLS = 2,
    parameter int MEM_STALLS  = 1,
    parameter int CNT_W       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] ex_dst,
    input  logic       mem_memread,
    input  logic [4:0] mem_dst,
    input  logic       branch_taken,
    output logic       stall,
    output logic       resolve,
    output logic       pc_sel,
    output logic       flush_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             is_br, use_rt, hz_ex, hz_mem;
    logic [CNT_W-1:0] ex_need, mem_need, need;

    // Hazard detection; register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        use_rt   = (id_op == `OP_BEQ) || (id_op == `OP_BNE);
        is_br    = id_valid && (use_rt || (id_op == `OP_BGTZ) ||
                                (id_op == `OP_BGEZ) || (id_op == `OP_BLEZ));
        hz_ex    = ex_regwrite && (ex_dst != 5'd0) &&
                   ((ex_dst == id_rs) || (use_rt && (ex_dst == id_rt)));
        hz_mem   = mem_memread && (mem_dst != 5'd0) &&
                   ((mem_dst == id_rs) || (use_rt && (mem_dst == id_rt)));
        ex_need  = '0;
        if (hz_ex) begin
            ex_need = ex_memread ? CNT_W'(LOAD_STALLS) : CNT_W'(ALU_STALLS);
        end
        mem_need = hz_mem ? CNT_W'(MEM_STALLS) : '0;
        need     = (ex_need > mem_need) ? ex_need : mem_need;
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        resolve = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (is_br) begin
                        if (need == '0) begin
                            resolve = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = need - 1'b1;
                            state_d = (need == CNT_W'(1)) ? RESOLVE : STALL;
                        end
                    end
                end
                // cnt_q holds the stall cycles still owed, including this one.
                STALL: begin
                    if (!id_valid) begin
                        state_d = IDLE;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    resolve = id_valid;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_sel = resolve & branch_taken;

`ifdef MIPS_DELAY_SLOT_EN
    assign flush_if = 1'b0;
`else
    assign flush_if = resolve & branch_taken;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: per-cycle vector table with a scoreboard queue,
// plus hand-written reset / flush / back-to-back sequences.

module tb_branch_resolve_ctrl;

    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_BNE  = 6'h05;
    localparam logic [5:0] OPC_BLEZ = 6'h06;
    localparam logic [5:0] OPC_BGTZ = 6'h07;
    localparam logic [5:0] OPC_BGEZ = 6'h01;
    localparam logic [5:0] OPC_ADD  = 6'h00;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       exw;
        logic       exl;
        logic [4:0] exd;
        logic       meml;
        logic [4:0] memd;
        logic       tk;
        logic       e_stall;
        logic       e_res;
        logic       e_pc;
    } vec_t;

    typedef struct packed {
        logic stall;
        logic res;
        logic pc;
        logic fl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt;
    logic       ex_regwrite, ex_memread;
    logic [4:0] ex_dst;
    logic       mem_memread;
    logic [4:0] mem_dst;
    logic       branch_taken;
    logic       stall, resolve, pc_sel, flush_if;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_resolve = 0;
    vec_t tbl[$];
    exp_t sb[$];

    branch_resolve_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_dst      (ex_dst),
        .mem_memread (mem_memread),
        .mem_dst     (mem_dst),
        .branch_taken(branch_taken),
        .stall       (stall),
        .resolve     (resolve),
        .pc_sel      (pc_sel),
        .flush_if    (flush_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic vl, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic exw, input logic exl, input logic [4:0] exd,
                               input logic meml, input logic [4:0] memd, input logic tk,
                               input logic es, input logic er, input logic ep);
        vec_t t;
        t.rst = r;   t.vld = vl;   t.op = op;     t.rs = rs;   t.rt = rt;
        t.exw = exw; t.exl = exl;  t.exd = exd;   t.meml = meml; t.memd = memd;
        t.tk = tk;   t.e_stall = es; t.e_res = er; t.e_pc = ep;
        return t;
    endfunction

    function automatic vec_t idle_vec();
        return v(0, 0, OPC_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare on the falling edge.
    task automatic step(input vec_t t, input string tag);
        exp_t e;
        exp_t got;
        rst          = t.rst;
        id_valid     = t.vld;
        id_op        = t.op;
        id_rs        = t.rs;
        id_rt        = t.rt;
        ex_regwrite  = t.exw;
        ex_memread   = t.exl;
        ex_dst       = t.exd;
        mem_memread  = t.meml;
        mem_dst      = t.memd;
        branch_taken = t.tk;
        e.stall = t.e_stall;
        e.res   = t.e_res;
        e.pc    = t.e_pc;
`ifdef MIPS_DELAY_SLOT_EN
        e.fl    = 1'b0;
`else
        e.fl    = t.e_res & t.tk;
`endif
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        if (resolve === 1'b1) n_resolve++;
        check({tag, ".stall"},    int'(stall),    int'(got.stall));
        check({tag, ".resolve"},  int'(resolve),  int'(got.res));
        check({tag, ".pc_sel"},   int'(pc_sel),   int'(got.pc));
        check({tag, ".flush_if"}, int'(flush_if), int'(got.fl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        step_init();

        // rst, vld, op, rs, rt, exw, exl, exd, meml, memd, tk | stall, resolve, pc_sel
        tbl.push_back(v(1, 1, OPC_BEQ,  1, 2, 0, 0, 0, 0, 0, 1,  0, 0, 0)); // reset masks outputs
        tbl.push_back(v(1, 0, OPC_ADD,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 1, OPC_BEQ,  1, 2, 0, 0, 0, 0, 0, 1,  0, 1, 1)); // no hazard
        tbl.push_back(idle_vec());
        tbl.push_back(v(0, 1, OPC_BNE,  3, 4, 1, 0, 4, 0, 0, 1,  1, 0, 0)); // EX ALU -> rt
        tbl.push_back(v(0, 1, OPC_BNE,  3, 4, 1, 0, 4, 0, 0, 1,  0, 1, 1));
        tbl.push_back(v(0, 1, OPC_BNE,  3, 4, 1, 0, 4, 0, 0, 1,  1, 0, 0));
        tbl.push_back(v(0, 1, OPC_BNE,  3, 4, 1, 0, 4, 0, 0, 0,  0, 1, 0)); // not taken
        tbl.push_back(idle_vec());
        tbl.push_back(v(0, 1, OPC_BGTZ, 5, 9, 1, 1, 5, 0, 0, 1,  1, 0, 0)); // EX load -> 2 stalls
        tbl.push_back(v(0, 1, OPC_BGTZ, 5, 9, 1, 1, 5, 0, 0, 1,  1, 0, 0));
        tbl.push_back(v(0, 1, OPC_BGTZ, 5, 9, 1, 1, 5, 0, 0, 1,  0, 1, 1));
        tbl.push_back(v(0, 1, OPC_BGTZ, 5, 9, 1, 0, 9, 0, 0, 0,  0, 1, 0)); // rt unused
        tbl.push_back(idle_vec());
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 1, 0, 6, 1, 7, 1,  1, 0, 0)); // EX ALU + MEM load
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 1, 0, 6, 1, 7, 1,  0, 1, 1));
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 1, 1, 6, 1, 7, 1,  1, 0, 0)); // EX load wins
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 1, 1, 6, 1, 7, 1,  1, 0, 0));
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 1, 1, 6, 1, 7, 1,  0, 1, 1));
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 0, 0, 0, 1, 7, 1,  1, 0, 0)); // MEM load only
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 0, 0, 0, 1, 7, 1,  0, 1, 1));
        tbl.push_back(v(0, 1, OPC_BEQ,  6, 7, 0, 0, 0, 0, 7, 1,  0, 1, 1)); // MEM non-load
        tbl.push_back(v(0, 1, OPC_BEQ,  0, 3, 1, 0, 0, 0, 0, 1,  0, 1, 1)); // dst r0
        tbl.push_back(v(0, 1, OPC_BLEZ, 8, 2, 1, 0, 8, 0, 0, 0,  1, 0, 0));
        tbl.push_back(v(0, 1, OPC_BLEZ, 8, 2, 1, 0, 8, 0, 0, 0,  0, 1, 0));
        tbl.push_back(v(0, 1, OPC_BGEZ, 10, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(v(0, 1, OPC_ADD,  1, 2, 1, 1, 1, 1, 2, 1,  0, 0, 0)); // not a branch
        tbl.push_back(v(0, 0, OPC_BEQ,  1, 2, 1, 1, 1, 1, 2, 1,  0, 0, 0)); // invalid ID
        tbl.push_back(idle_vec());

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Reset during the second stall cycle abandons the branch.
        step(v(0, 1, OPC_BGTZ, 5, 0, 1, 1, 5, 0, 0, 1, 1, 0, 0), "rst_mid.s1");
        step(v(1, 1, OPC_BGTZ, 5, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0), "rst_mid.rst");
        step(idle_vec(), "rst_mid.after");
        step(v(0, 1, OPC_BEQ, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 1), "rst_mid.next");

        // ID flushed while stalling.
        step(v(0, 1, OPC_BGTZ, 5, 0, 1, 1, 5, 0, 0, 1, 1, 0, 0), "flush_stall.s1");
        step(v(0, 0, OPC_BGTZ, 5, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0), "flush_stall.drop");
        step(idle_vec(), "flush_stall.after");
        step(v(0, 1, OPC_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0), "flush_stall.next");

        // ID flushed in the resolve cycle.
        step(v(0, 1, OPC_BNE, 3, 4, 1, 0, 4, 0, 0, 1, 1, 0, 0), "flush_res.s1");
        step(v(0, 0, OPC_BNE, 3, 4, 1, 0, 4, 0, 0, 1, 0, 0, 0), "flush_res.drop");
        step(v(0, 1, OPC_BNE, 3, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1), "flush_res.next");
        step(idle_vec(), "flush_res.idle");

        // Back-to-back branches: exactly two resolve pulses.
        n_resolve = 0;
        step(v(0, 1, OPC_BNE, 3, 4, 1, 0, 4, 0, 0, 1, 1, 0, 0), "b2b.stall");
        step(v(0, 1, OPC_BNE, 3, 4, 1, 0, 4, 0, 0, 1, 0, 1, 1), "b2b.res1");
        step(v(0, 1, OPC_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0), "b2b.res2");
        step(idle_vec(), "b2b.idle");
        check("b2b.resolve_count", n_resolve, 2);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic step_init();
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_op        = OPC_ADD;
        id_rs        = '0;
        id_rt        = '0;
        ex_regwrite  = 1'b0;
        ex_memread   = 1'b0;
        ex_dst       = '0;
        mem_memread  = 1'b0;
        mem_dst      = '0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
    endtask

endmodule
